// File: rtl/aca_error_recovery_32bit.sv
// Error detection and nibble-serial recovery for the 32-bit windowed
// approximate adder. A transaction is accepted in IDLE, checked in one
// cycle, optionally rebuilt exactly over six nibble cycles, then held in
// DONE until the downstream takes it.
module aca_error_recovery_32bit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [31:0]      approx_sum,
    input  logic             approx_cout,
    input  logic             corr_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_cout,
    output logic             out_err,
    output logic             out_corrected,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CHECK   = 2'd1;
    localparam logic [1:0] CORRECT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]  state;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] approx_sum_r;
    logic        approx_cout_r;
    logic        corr_en_r;
    logic [31:0] sum_r;
    logic        carry_r;
    logic [2:0]  nib_r;

    logic [6:1]  prop;
    logic [5:0]  gen;
    logic        err;
    logic        low_carry;
    logic [4:0]  nib_add;
    logic [31:0] sum_next;

    // Handshake flags follow directly from the state, so there is no overlap
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Nibble propagate/generate terms; an error exists exactly when a carry
    // generated in nibble k-1 would have run through a fully propagating nibble k
    always_comb begin
        prop = '0;
        gen  = '0;
        for (int k = 1; k <= 6; k++) begin
            prop[k] = &(a_r[4*k +: 4] ^ b_r[4*k +: 4]);
        end
        for (int k = 0; k <= 5; k++) begin
            gen[k] = (({1'b0, a_r[4*k +: 4]} + {1'b0, b_r[4*k +: 4]}) > 5'd15);
        end
        err       = |(prop & gen);
        low_carry = gen[1] | (prop[1] & gen[0]);
    end

    // One nibble of the exact ripple, spliced into the partially rebuilt sum
    always_comb begin
        nib_add  = {1'b0, a_r[{nib_r, 2'b00} +: 4]} + {1'b0, b_r[{nib_r, 2'b00} +: 4]}
                 + {4'b0000, carry_r};
        sum_next = sum_r;
        sum_next[{nib_r, 2'b00} +: 4] = nib_add[3:0];
    end

    // Control FSM, operand capture, correction datapath, result and error counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_r           <= '0;
            b_r           <= '0;
            approx_sum_r  <= '0;
            approx_cout_r <= 1'b0;
            corr_en_r     <= 1'b0;
            sum_r         <= '0;
            carry_r       <= 1'b0;
            nib_r         <= 3'd0;
            out_sum       <= '0;
            out_cout      <= 1'b0;
            out_err       <= 1'b0;
            out_corrected <= 1'b0;
            err_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r           <= a;
                        b_r           <= b;
                        approx_sum_r  <= approx_sum;
                        approx_cout_r <= approx_cout;
                        corr_en_r     <= corr_en;
                        state         <= CHECK;
                    end
                end
                CHECK: begin
                    if (err && (err_count != {CNT_W{1'b1}})) begin
                        err_count <= err_count + CNT_W'(1);
                    end
                    if (!err || !corr_en_r) begin
                        out_sum       <= approx_sum_r;
                        out_cout      <= approx_cout_r;
                        out_err       <= err;
                        out_corrected <= 1'b0;
                        state         <= DONE;
                    end else begin
                        sum_r   <= {24'h000000, approx_sum_r[7:0]};
                        carry_r <= low_carry;
                        nib_r   <= 3'd2;
                        state   <= CORRECT;
                    end
                end
                CORRECT: begin
                    sum_r   <= sum_next;
                    carry_r <= nib_add[4];
                    nib_r   <= nib_r + 3'd1;
                    if (nib_r == 3'd7) begin
                        out_sum       <= sum_next;
                        out_cout      <= nib_add[4];
                        out_err       <= 1'b1;
                        out_corrected <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aca_error_recovery_32bit.sv
// Self-checking bench for aca_error_recovery_32bit: a reference model of the
// windowed adder predicts each result into a scoreboard queue, and a monitor
// pops and compares when out_valid rises.
module tb_aca_error_recovery_32bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] approx_sum;
    logic        approx_cout;
    logic        corr_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_err;
    logic        out_corrected;
    logic [15:0] err_count;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        err;
        logic        corr;
        logic [15:0] cnt;
        int          edges;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    int          cycle = 0;
    logic [15:0] model_cnt = '0;
    logic        prev_valid = 1'b0;

    aca_error_recovery_32bit #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .approx_sum(approx_sum), .approx_cout(approx_cout),
        .corr_en(corr_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_err(out_err),
        .out_corrected(out_corrected), .err_count(err_count)
    );

    // 10 ns clock and a free-running edge counter for latency measurement
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Windowed approximate adder: {cout, sum}
    function automatic logic [32:0] approxModel(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] s;
        logic [8:0]  t;
        logic        c;
        t      = {1'b0, x[7:0]} + {1'b0, y[7:0]};
        s      = '0;
        s[7:0] = t[7:0];
        c      = 1'b0;
        for (int n = 2; n <= 7; n++) begin
            t = {1'b0, x[4*n-4 +: 8]} + {1'b0, y[4*n-4 +: 8]};
            s[4*n +: 4] = t[7:4];
            if (n == 7) c = t[8];
        end
        return {c, s};
    endfunction

    // Drive one transaction in IDLE and push its predicted result
    task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb,
                                 input logic [31:0] ts, input logic tc, input logic te);
        exp_t        e;
        logic [32:0] exact;
        @(negedge clk);
        checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
        a = ta; b = tb; approx_sum = ts; approx_cout = tc; corr_en = te;
        in_valid = 1'b1;
        exact = {1'b0, ta} + {1'b0, tb};
        e.err = ({tc, ts} != exact);
        if (e.err && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        e.cnt = model_cnt;
        if (e.err && te) begin
            e.sum = exact[31:0]; e.cout = exact[32]; e.corr = 1'b1; e.edges = 8;
        end else begin
            e.sum = ts; e.cout = tc; e.corr = 1'b0; e.edges = 2;
        end
        @(posedge clk);
        #1;
        e.acc = cycle;
        sb.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic waitPop();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("result_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("return_idle", 64'(out_valid), 64'd0);
    endtask

    task automatic runOne(input logic [31:0] ta, input logic [31:0] tb,
                          input logic [31:0] ts, input logic tc, input logic te);
        applyStimulus(ta, tb, ts, tc, te);
        waitPop();
        waitIdle();
    endtask

    // Monitor: compare on the first cycle of each out_valid pulse
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("out_sum", 64'(out_sum), 64'(e.sum));
                checkOutput("out_cout", 64'(out_cout), 64'(e.cout));
                checkOutput("out_err", 64'(out_err), 64'(e.err));
                checkOutput("out_corrected", 64'(out_corrected), 64'(e.corr));
                checkOutput("err_count", 64'(err_count), 64'(e.cnt));
                checkOutput("latency", 64'(cycle - e.acc + 1), 64'(e.edges));
            end
        end
        prev_valid = out_valid;
    end

    // Hard stop in case something above never returns
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence
    initial begin
        logic [32:0] ap;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; approx_sum = '0; approx_cout = 1'b0; corr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_sum", 64'(out_sum), 64'd0);
        checkOutput("rst_flags", 64'({out_cout, out_err, out_corrected}), 64'd0);
        checkOutput("rst_err_count", 64'(err_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        runOne(32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b1);
        runOne(32'h00000F10, 32'h000000F0, 32'h00000000, 1'b0, 1'b1);
        runOne(32'hFFFFFFFF, 32'h00000001, 32'hFFFFFF00, 1'b0, 1'b1);
        runOne(32'h00000F10, 32'h000000F0, 32'h00000000, 1'b0, 1'b0);

        $display("[TB] random vectors");
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : (~ra ^ (32'h1 << $urandom_range(0, 31)));
            ap = approxModel(ra, rb);
            runOne(ra, rb, ap[31:0], ap[32], 1'($urandom_range(0, 1)));
        end

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(32'h00000F10, 32'h000000F0, 32'h00000000, 1'b0, 1'b1);
        waitPop();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = $urandom; b = $urandom;
            checkOutput("stall_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
            checkOutput("stall_sum", 64'(out_sum), 64'h1000);
            checkOutput("stall_corrected", 64'(out_corrected), 64'd1);
            checkOutput("stall_err_count", 64'(err_count), 64'(model_cnt));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_valid", 64'(out_valid), 64'd0);
        checkOutput("release_in_ready", 64'(in_ready), 64'd1);
        repeat (4) @(posedge clk);

        $display("[TB] reset during correction");
        applyStimulus(32'hFFFFFFFF, 32'h00000001, 32'hFFFFFF00, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        model_cnt = '0;
        @(posedge clk);
        #1;
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_sum", 64'(out_sum), 64'd0);
        checkOutput("midrst_flags", 64'({out_cout, out_err, out_corrected}), 64'd0);
        checkOutput("midrst_err_count", 64'(err_count), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        runOne(32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b1);
        repeat (3) @(posedge clk);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
